// File: rtl/keypad_sequencer_if.sv
// rtl/keypad_sequencer_if.sv - key press handshake between keypad source and keypad_sequencer
interface keypad_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_sequencer.sv
// rtl/keypad_sequencer.sv - buffers keypad digits and replays them as one-hot groups on ENTER
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_sequencer #(
  parameter int NUM_PARTS       = 3,
  parameter int DIGITS_PER_PART = 4,
  parameter int IDLE_DIGIT      = 0,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  keypad_sequencer_if.slave     key_if,
  output logic [3:0][9:0]       digits_o,
  output logic                  burst_active_o,
  output logic [3:0]            entry_count_o,
  output logic                  err_o
);

  localparam int NUM_SLOTS = NUM_PARTS * DIGITS_PER_PART;
  localparam int PW        = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_BURST   = 1'b1;

  localparam logic [3:0]    FULL        = 4'(NUM_SLOTS);
  localparam logic [3:0]    KEY_MAX_DIG = 4'd9;
  localparam logic [3:0]    KEY_CLEAR   = 4'd10;
  localparam logic [3:0]    KEY_ENTER   = 4'd11;
  localparam logic [9:0]    IDLE_ONEHOT = 10'(1) << IDLE_DIGIT;
  localparam logic [PW-1:0] LAST_PART   = PW'(NUM_PARTS - 1);

  logic [0:0]                 state_q, state_d;
  logic [PW-1:0]              part_q, part_d;
  logic [3:0]                 count_q, count_d;
  logic                       err_q, err_d;
  logic [3:0][9:0]            digits_q, digits_d;
  logic [NUM_SLOTS-1:0][3:0]  slot_q;
  logic                       slot_we;
  logic                       accept;
  logic                       timeout_hit;

  assign accept = key_if.key_valid && (state_q == ST_COLLECT);

  // First key of a part lands on lane 3 (thousands), fourth on lane 0.
  function automatic logic [3:0][9:0] part_lanes(input logic [PW-1:0] p);
    logic [3:0][9:0] lanes;
    logic [3:0]      idx;
    for (int l = 0; l < 4; l++) begin
      idx      = 4'(int'(p) * DIGITS_PER_PART + (3 - l));
      lanes[l] = 10'(1) << slot_q[idx];
    end
    return lanes;
  endfunction

`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] idle_cnt_q;

  assign timeout_hit = (state_q == ST_COLLECT) && !accept &&
                       (count_q != 4'd0) && (count_q != FULL) &&
                       (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q != ST_COLLECT) || accept || timeout_hit ||
                 (count_q == 4'd0) || (count_q == FULL)) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end
`else
  // Partial entries are held forever; this comparison is constant false.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d  = state_q;
    part_d   = part_q;
    count_d  = count_q;
    err_d    = 1'b0;
    digits_d = digits_q;
    slot_we  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (key_if.key_code <= KEY_MAX_DIG) begin
            if (count_q < FULL) begin
              slot_we = 1'b1;
              count_d = count_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_if.key_code == KEY_CLEAR) begin
            count_d = 4'd0;
          end else if (key_if.key_code == KEY_ENTER) begin
            if (count_q == FULL) begin
              state_d  = ST_BURST;
              part_d   = '0;
              digits_d = part_lanes('0);
            end else begin
              err_d   = 1'b1;
              count_d = 4'd0;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          count_d = 4'd0;
        end
      end
      default: begin
        if (part_q == LAST_PART) begin
          state_d  = ST_COLLECT;
          part_d   = '0;
          count_d  = 4'd0;
          digits_d = {4{IDLE_ONEHOT}};
        end else begin
          part_d   = part_q + 1'b1;
          digits_d = part_lanes(part_q + 1'b1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_COLLECT;
      part_q   <= '0;
      count_q  <= 4'd0;
      err_q    <= 1'b0;
      digits_q <= {4{IDLE_ONEHOT}};
    end else begin
      state_q  <= state_d;
      part_q   <= part_d;
      count_q  <= count_d;
      err_q    <= err_d;
      digits_q <= digits_d;
    end
  end

  // Slots survive reset and CLEAR; entry count alone decides which are valid.
  always_ff @(posedge clk) begin
    if (slot_we) begin
      slot_q[count_q] <= key_if.key_code;
    end
  end

  assign key_if.key_ready = (state_q == ST_COLLECT);
  assign burst_active_o   = (state_q == ST_BURST);
  assign entry_count_o    = count_q;
  assign err_o            = err_q;
  assign digits_o         = digits_q;

endmodule
